poly_sched: RTL and testbench

Parametrised polyphony scheduler: successor to the fixed-depth polyphony controller. It time-multiplexes one shared iterative divider across `N` oscillators, accumulates each result, then holds the finished sample until the sample-rate strobe. It adds three behaviours:
- a per-frame voice-enable mask, so disabled voices are skipped;
- a divider watchdog that abandons a stalled division;
- an overrun flag for sample strobes that arrive before the frame completes.

It sits between the oscillator bank/divider datapath and the sample output register.

---
 rtl/poly_pkg.sv | 16 +
 rtl/poly_wdog.sv | 37 +++
 rtl/poly_sched.sv | 116 +++++++++++
 tb/tb_poly_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared types for the polyphony scheduler: FSM state encoding and a small
// width helper used by the watchdog counter.
package poly_pkg;

  typedef enum logic [1:0] {
    START_DIV = 2'd0,
    DONE_DIV  = 2'd1,
    HOLD_SAMP = 2'd2
  } poly_state_t;

  // Counter width able to hold 0..limit-1 (at least one bit).
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/poly_wdog.sv
// Divider watchdog: counts cycles a voice has waited for ready and flags
// expiry on the last permitted cycle. TIMEOUT=0 disables expiry entirely.
module poly_wdog
  import poly_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] wcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (clear) begin
      wcnt <= '0;
    end else if (enable) begin
      wcnt <= wcnt + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = enable && (wcnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/poly_sched.sv
// Polyphony scheduler: walks N voices through one shared divider, skips
// masked voices, abandons stalled divisions and holds the sample for the strobe.
module poly_sched
  import poly_pkg::*;
#(
  parameter int N       = 10,
  parameter int TIMEOUT = 64,
  parameter int OSC_W   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             samp_enable,
  input  logic [N-1:0]     osc_en,
  output logic             start,
  output logic             acc,
  output logic             store_samp,
  output logic             clr,
  output logic [OSC_W-1:0] osc_num,
  output logic             busy,
  output logic             div_timeout,
  output logic             overrun
);

  localparam int PW = 1 << OSC_W;

  poly_state_t      state, state_d;
  logic [OSC_W-1:0] osc_d;
  logic [N-1:0]     en_q, en_d;
  logic [PW-1:0]    en_pad;
  logic             voice_en;
  logic             advance;
  logic             wd_en;
  logic             wd_expire;

  // Zero-padded mask so osc_num (which reaches N in HOLD_SAMP) indexes safely.
  assign en_pad   = PW'(en_q);
  assign voice_en = en_pad[osc_num];
  assign wd_en    = (state == START_DIV) && voice_en && !ready;

  poly_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (advance),
    .enable(wd_en),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= START_DIV;
      osc_num <= '0;
      en_q    <= '1;
    end else begin
      state   <= state_d;
      osc_num <= osc_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d     = state;
    osc_d       = osc_num;
    en_d        = en_q;
    advance     = 1'b0;
    start       = 1'b0;
    acc         = 1'b0;
    store_samp  = 1'b0;
    clr         = 1'b0;
    div_timeout = 1'b0;
    busy        = (state != HOLD_SAMP);
    overrun     = samp_enable && (state != HOLD_SAMP);

    case (state)
      START_DIV: begin
        if (voice_en) begin
          start = 1'b1;
          // ready takes priority over a coincident watchdog expiry
          if (ready) begin
            state_d = DONE_DIV;
          end else if (wd_expire) begin
            div_timeout = 1'b1;
            advance     = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      DONE_DIV: begin
        acc     = 1'b1;
        advance = 1'b1;
      end
      HOLD_SAMP: begin
        store_samp = samp_enable;
        clr        = samp_enable;
        if (samp_enable) begin
          state_d = START_DIV;
          osc_d   = '0;
          en_d    = osc_en;
        end
      end
      default: begin
        state_d = START_DIV;
        osc_d   = '0;
      end
    endcase

    if (advance) begin
      osc_d   = osc_num + OSC_W'(1);
      state_d = (osc_num == OSC_W'(N - 1)) ? HOLD_SAMP : START_DIV;
    end
  end

endmodule

// File: tb/tb_poly_sched.sv
// Bench for poly_sched (N=4, TIMEOUT=5): frame-level reference model feeding
// event queues, a reactive divider responder and a decoupled output monitor.
module tb_poly_sched;

  localparam int N   = 4;
  localparam int TO  = 5;
  localparam int OW  = $clog2(N + 1);
  localparam int W   = 8;
  localparam int NF  = 24;

  localparam int K_ACC   = 0;
  localparam int K_TOUT  = 1;
  localparam int K_STORE = 2;
  localparam int K_OVR   = 3;

  logic          clk;
  logic          rst;
  logic          ready;
  logic          samp_enable;
  logic [N-1:0]  osc_en;
  logic          start;
  logic          acc;
  logic          store_samp;
  logic          clr;
  logic [OW-1:0] osc_num;
  logic          busy;
  logic          div_timeout;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] ev_q[$];
  logic [W-1:0] samp_q[$];
  int           len_q[$];
  int           delay[N];
  bit           mon_en = 1'b0;

  poly_sched #(
    .N      (N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .samp_enable(samp_enable),
    .osc_en     (osc_en),
    .start      (start),
    .acc        (acc),
    .store_samp (store_samp),
    .clr        (clr),
    .osc_num    (osc_num),
    .busy       (busy),
    .div_timeout(div_timeout),
    .overrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] code(input int kind, input int osc);
    return W'(kind * 16 + osc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_ev(input string name, input logic [W-1:0] act);
    if (ev_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event %0d expected no event", name, act);
    end else begin
      check(name, 32'(act), 32'(ev_q.pop_front()));
    end
  endtask

  task automatic pop_samp(input string name, input logic [W-1:0] act);
    if (samp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got event %0d expected no event", name, act);
    end else begin
      check(name, 32'(act), 32'(samp_q.pop_front()));
    end
  endtask

  // Reference model: a frame visits every voice in order. A disabled voice
  // costs 1 cycle; an enabled voice answered after d waiting cycles costs d+2
  // and accumulates, unless d reaches TO, in which case it costs TO and times out.
  task automatic plan_frame(input logic [N-1:0] mask, output int len);
    len = 0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        len += 1;
      end else if (delay[i] < TO) begin
        ev_q.push_back(code(K_ACC, i));
        len += delay[i] + 2;
      end else begin
        ev_q.push_back(code(K_TOUT, i));
        len += TO;
      end
    end
    len_q.push_back(len);
  endtask

  // Directed frames first, then random ones.
  task automatic setup_frame(input int f, input int len_hint, output logic [N-1:0] mask);
    for (int i = 0; i < N; i++) delay[i] = 0;
    case (f)
      1: mask = 4'b0101;
      2: begin mask = 4'hF; delay[1] = 9; end
      3: mask = 4'h0;
      4: begin mask = 4'hF; delay[0] = 4; delay[2] = 5; end
      5: mask = 4'h1;
      default: begin
        mask = N'($urandom);
        for (int i = 0; i < N; i++) delay[i] = $urandom_range(0, 7);
      end
    endcase
    if (len_hint < 0) mask = mask;
  endtask

  // ---------------- divider responder ----------------
  initial begin
    int wait_cnt;
    bit cnt_valid;
    int prev_osc;
    wait_cnt  = 0;
    cnt_valid = 1'b0;
    prev_osc  = 0;
    ready     = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !start) begin
        wait_cnt  = 0;
        cnt_valid = 1'b0;
      end else if (cnt_valid && int'(osc_num) == prev_osc) begin
        wait_cnt++;
      end else begin
        wait_cnt  = 0;
        cnt_valid = 1'b1;
      end
      prev_osc = int'(osc_num);
      ready = !rst && start && (int'(osc_num) < N) && (wait_cnt >= delay[int'(osc_num) % N]);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        busy_cnt = 0;
      end else begin
        if (acc) pop_ev("acc_event", code(K_ACC, int'(osc_num)));
        if (div_timeout) pop_ev("timeout_event", code(K_TOUT, int'(osc_num)));
        if (store_samp) pop_samp("store_event", code(K_STORE, 0));
        if (overrun) pop_samp("overrun_event", code(K_OVR, 0));
        if (store_samp || overrun) check("clr_matches_store", 32'(clr), 32'(store_samp));
        if (busy) begin
          busy_cnt++;
        end else begin
          if (busy_cnt != 0) begin
            if (len_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL frame_len: got %0d expected no frame", busy_cnt);
            end else begin
              check("frame_len", 32'(busy_cnt), 32'(len_q.pop_front()));
            end
            busy_cnt = 0;
          end
          check("hold_osc_num", 32'(osc_num), 32'(N));
          check("hold_quiet", {29'd0, start, acc, div_timeout}, 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    logic [N-1:0] mask;
    int len;
    int ovr_at;
    bit aborted;
    rst         = 1'b1;
    samp_enable = 1'b0;
    osc_en      = '0;
    aborted     = 1'b0;
    for (int i = 0; i < N; i++) delay[i] = 0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start", 32'(start), 32'd1);
    check("rst_osc_num", 32'(osc_num), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_quiet", {26'd0, acc, store_samp, clr, div_timeout, overrun, 1'b0}, 32'd0);

    // run into the frame, then reset asynchronously at osc_num 3
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 50 && osc_num != OW'(3); i++) begin
      @(posedge clk); #1;
    end
    check("reach_osc3", 32'(osc_num), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_osc_num", 32'(osc_num), 32'd0);
    check("midrst_start", 32'(start), 32'd1);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_acc", 32'(acc), 32'd0);

    // frame 0 uses the reset mask (all ones) whatever osc_en says
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) delay[i] = 0;
    plan_frame(4'hF, len);
    ovr_at = -1;
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int f = 0; f < NF && !aborted; f++) begin
      for (int k = 0; ; k++) begin
        if (!busy) break;
        if (k >= 300) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_timeout: got busy after %0d cycles expected %0d", k, len);
          aborted = 1'b1;
          break;
        end
        osc_en = N'($urandom);
        if (k == ovr_at) begin
          samp_enable = 1'b1;
          samp_q.push_back(code(K_OVR, 0));
        end
        @(posedge clk); #1;
        samp_enable = 1'b0;
      end
      if (aborted || f == NF - 1) break;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      setup_frame(f + 1, len, mask);
      osc_en      = mask;
      samp_enable = 1'b1;
      samp_q.push_back(code(K_STORE, 0));
      plan_frame(mask, len);
      if (f + 1 == 2) ovr_at = 2;
      else if (f + 1 > 5 && $urandom_range(0, 2) == 0) ovr_at = $urandom_range(0, len - 1);
      else ovr_at = -1;
      @(posedge clk); #1;
      samp_enable = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("ev_q_drained", 32'(ev_q.size()), 32'd0);
    check("samp_q_drained", 32'(samp_q.size()), 32'd0);
    check("len_q_drained", 32'(len_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
